stall_mem_responder: RTL and testbench

- Multi-cycle, word-addressed memory responder that serves the pipeline's instruction-fetch and data-memory ports.
- Single outstanding request. The requester issues Rd/Wr with Addr/DataIn. The block answers with Stall while busy, then a one-cycle Done pulse with DataOut.
- Replaces the single-cycle memory behind the fetch and mem stages, so stall handling (PC hold, pipeline freeze) can be exercised.

---
 rtl/stall_mem_responder.sv | 107 ++++++++++
 tb/tb_stall_mem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/stall_mem_responder.sv
// Multi-cycle word-addressed memory responder: Stall while busy, then a one-cycle Done.
// Define MEM_RAND_STALL_EN to add 0..3 LFSR-driven extra Stall cycles per accepted request.
module stall_mem_responder #(
    parameter int MEM_AW  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Stall,
    output logic        Done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

    state_t            state, state_nxt;
    logic [4:0]        count, count_nxt;
    logic [4:0]        extra;
    logic [MEM_AW-1:0] idx;
    logic [15:0]       wdata;
    logic              op_wr;
    logic              req, legal, accept, reject, finish;
    logic [15:0]       mem [2**MEM_AW];

    // Address bits above the word index wrap around silently.
    wire unused_addr = &{1'b0, Addr[15:MEM_AW+1]};

    assign req    = Rd | Wr;
    assign legal  = (Rd ^ Wr) & ~Addr[0];
    assign finish = (state == BUSY) && (count == 5'd0);

`ifdef MEM_RAND_STALL_EN
    logic [3:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        lfsr <= 4'b1001;
        else if (accept) lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end

    assign extra = {3'b000, lfsr[1:0]};
`else
    assign extra = 5'd0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        count_nxt = count;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            BUSY: begin
                if (count != 5'd0) count_nxt = count - 5'd1;
                else               state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
                if (req && legal) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                    count_nxt = LAT_M1 + extra;
                end else if (req) begin
                    reject = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= 5'd0;
            Stall   <= 1'b0;
            Done    <= 1'b0;
            err     <= 1'b0;
            DataOut <= 16'h0000;
            idx     <= '0;
            wdata   <= 16'h0000;
            op_wr   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            Stall <= (state_nxt == BUSY);
            Done  <= (state_nxt == DONE);
            err   <= reject;
            if (accept) begin
                idx   <= Addr[MEM_AW:1];
                wdata <= DataIn;
                op_wr <= Wr;
            end
            if (finish && !op_wr) DataOut <= mem[idx];
        end
    end

    // NOTE: the array has no reset; a reset during BUSY drops state, so no write commits.
    always_ff @(posedge clk) begin
        if (finish && op_wr) mem[idx] <= wdata;
    end

endmodule

// File: tb/tb_stall_mem_responder.sv
// Directed bench for stall_mem_responder with a scoreboard of expected completions.
// Honours MEM_RAND_STALL_EN by modelling the LFSR stall extension.
module tb_stall_mem_responder;

    localparam int MEM_AW = 10;
`ifdef MEM_RAND_STALL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        int          stall_len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn, DataOut;
    logic        Rd, Wr, Stall, Done, err;

    exp_t        sb[$];
    logic [15:0] model_mem [1 << MEM_AW];
    logic [15:0] last_read;
    logic [3:0]  model_lfsr;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    stall_mem_responder #(.MEM_AW(MEM_AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Stall(Stall), .Done(Done), .err(err)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int next_stall();
        int extra_cycles = 0;
`ifdef MEM_RAND_STALL_EN
        extra_cycles = int'(model_lfsr[1:0]);
        model_lfsr   = {model_lfsr[2:0], model_lfsr[3] ^ model_lfsr[2]};
`endif
        return LAT + extra_cycles;
    endfunction

    // Drives one request for one cycle; legal tracked requests go onto the scoreboard.
    task automatic start_req(input bit rd, input bit wr, input logic [15:0] a,
                             input logic [15:0] d, input bit track);
        exp_t e;
        int   stall;
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        if ((rd ^ wr) && !a[0]) begin
            stall = next_stall();
            if (track) begin
                e.is_read   = rd;
                e.stall_len = stall;
                if (rd) e.data = model_mem[a[MEM_AW:1]];
                else begin
                    model_mem[a[MEM_AW:1]] = d;
                    e.data = d;
                end
                sb.push_back(e);
            end
        end
        @(negedge clk);
        Rd = 1'b0; Wr = 1'b0;
    endtask

    // Counts Stall cycles (bounded), then checks the Done cycle against the scoreboard head.
    task automatic finish_req(input string tag, input bit chain, input int pre);
        exp_t e;
        int   n = pre;
        while (Stall === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed=none expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, " stall_len"}, 16'(n), 16'(e.stall_len));
        check({tag, " done"}, 16'(Done), 16'h0001);
        if (e.is_read) begin
            check({tag, " rdata"}, DataOut, e.data);
            last_read = e.data;
        end else begin
            check({tag, " hold"}, DataOut, last_read);
        end
        if (!chain) begin
            @(negedge clk);
            check({tag, " done_clear"}, 16'(Done), 16'h0000);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;
        model_lfsr = 4'b1001;
        last_read  = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst stall", 16'(Stall), 16'h0000);
        check("rst done", 16'(Done), 16'h0000);
        check("rst err", 16'(err), 16'h0000);
        check("rst dataout", DataOut, 16'h0000);
        rst = 1'b1;
        @(negedge clk);

        // Basic write/read, then back-to-back reads issued in the Done cycle.
        start_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b1);
        finish_req("wr_beef", 1'b0, 0);
        start_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
        finish_req("rd_beef", 1'b1, 0);
        start_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
        finish_req("b2b_rd", 1'b1, 0);
        start_req(1'b1, 1'b0, 16'h0810, 16'h0000, 1'b1);
        finish_req("wrap_rd", 1'b0, 0);

        // Illegal requests: both ops, then misaligned address.
        start_req(1'b0, 1'b1, 16'h0004, 16'h1111, 1'b1);
        finish_req("wr4", 1'b0, 0);
        Rd = 1'b1; Wr = 1'b1; Addr = 16'h0004; DataIn = 16'h2222;
        @(negedge clk);
        Rd = 1'b0; Wr = 1'b0;
        check("both err", 16'(err), 16'h0001);
        check("both stall", 16'(Stall), 16'h0000);
        @(negedge clk);
        check("both err_clear", 16'(err), 16'h0000);
        check("both no_done", 16'(Done), 16'h0000);
        start_req(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1);
        finish_req("rd4_unchanged", 1'b0, 0);
        Rd = 1'b1; Addr = 16'h0003;
        @(negedge clk);
        Rd = 1'b0;
        check("odd err", 16'(err), 16'h0001);
        check("odd stall", 16'(Stall), 16'h0000);
        repeat (3) begin
            @(negedge clk);
            check("odd no_done", 16'(Done), 16'h0000);
        end

        // Read asserted while busy must be ignored.
        start_req(1'b0, 1'b1, 16'h0020, 16'h1234, 1'b1);
        check("coll busy", 16'(Stall), 16'h0001);
        Rd = 1'b1; Addr = 16'h0020;
        @(negedge clk);
        Rd = 1'b0;
        check("coll no_err", 16'(err), 16'h0000);
        finish_req("coll_wr", 1'b0, 1);
        repeat (3) begin
            check("coll no_done", 16'(Done), 16'h0000);
            check("coll no_stall", 16'(Stall), 16'h0000);
            @(negedge clk);
        end

        // Reset during the first Stall cycle of a write must not commit it.
        start_req(1'b0, 1'b1, 16'h0030, 16'h5555, 1'b1);
        finish_req("wr30", 1'b0, 0);
        start_req(1'b0, 1'b1, 16'h0030, 16'hAAAA, 1'b0);
        check("midrst busy", 16'(Stall), 16'h0001);
        rst = 1'b0;
        #1;
        check("midrst stall", 16'(Stall), 16'h0000);
        check("midrst done", 16'(Done), 16'h0000);
        check("midrst err", 16'(err), 16'h0000);
        check("midrst dataout", DataOut, 16'h0000);
        model_lfsr = 4'b1001;
        last_read  = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_req(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1);
        finish_req("rd30_prior", 1'b0, 0);

        // Four consecutive reads, chained through their Done cycles.
        start_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
        finish_req("seq_rd0", 1'b1, 0);
        start_req(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1);
        finish_req("seq_rd1", 1'b1, 0);
        start_req(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1);
        finish_req("seq_rd2", 1'b1, 0);
        start_req(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1);
        finish_req("seq_rd3", 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
